// File: rtl/freq_report_pkg.sv
// Shared definitions for the frequency report stage: bin width, parameter
// defaults and report entry layout.
package freq_report_pkg;
  localparam int FREQ_W         = 4;
  localparam int STABLE_N_DEF   = 3;
  localparam int CNT_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  // Report entry is {freq, frame index}.
  function automatic int entry_w(input int cnt_w);
    return FREQ_W + cnt_w;
  endfunction
endpackage

// File: rtl/freq_report_fifo.sv
// Synchronous report FIFO: valid/ready pop, push with drop-on-full, and a
// head register that holds the last popped entry while empty.
module freq_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         valid,
  output logic [W-1:0] head,
  output logic         drop
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [W-1:0]     last_q;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign valid = (count != '0);
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign pop   = valid & pop_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;
  assign head  = valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/freq_report.sv
// Confirms a dominant frequency after STABLE_N identical frames and queues
// each confirmed change, with its frame index, for a host consumer.
module freq_report
  import freq_report_pkg::*;
#(
  parameter int STABLE_N   = STABLE_N_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [FREQ_W-1:0] freq,
  input  logic              rpt_ready,
  input  logic              ovf_clr,
  output logic              rpt_valid,
  output logic [FREQ_W-1:0] rpt_freq,
  output logic [CNT_W-1:0]  rpt_frame,
  output logic              ovf,
  output logic [FREQ_W-1:0] cur_freq,
  output logic              cur_vld
);
  localparam int ENTRY_W = entry_w(CNT_W);

  logic [CNT_W-1:0]   frame_cnt;
  logic [CNT_W-1:0]   run_len;
  logic [CNT_W-1:0]   run_len_nxt;
  logic [FREQ_W-1:0]  last_freq;
  logic               confirm;
  logic               drop;
  logic [ENTRY_W-1:0] head;

  always_comb begin
    run_len_nxt = run_len;
    if (done) begin
      if (run_len != '0 && freq == last_freq)
        run_len_nxt = (run_len == '1) ? run_len : run_len + 1'b1;
      else
        run_len_nxt = CNT_W'(1);
    end
  end

  // Only the frame that lands exactly on STABLE_N can confirm, so long or
  // saturated runs never re-report.
  assign confirm = done && (run_len_nxt == CNT_W'(STABLE_N)) &&
                   (!cur_vld || freq != cur_freq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      run_len   <= '0;
      last_freq <= '0;
      cur_freq  <= '0;
      cur_vld   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      run_len <= run_len_nxt;
      if (done) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (!(run_len != '0 && freq == last_freq)) last_freq <= freq;
      end
      if (confirm) begin
        cur_freq <= freq;
        cur_vld  <= 1'b1;
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  freq_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (confirm),
    .push_data ({freq, frame_cnt}),
    .pop_ready (rpt_ready),
    .valid     (rpt_valid),
    .head      (head),
    .drop      (drop)
  );

  assign rpt_freq  = head[ENTRY_W-1 -: FREQ_W];
  assign rpt_frame = head[CNT_W-1:0];
endmodule

// File: tb/tb_freq_report.sv
// Directed bench for freq_report: confirmation, repeat suppression,
// overflow/drop, full push+pop and mid-stream reset.
module tb_freq_report;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             done = 1'b0;
  logic [3:0]       freq = '0;
  logic             rpt_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             rpt_valid;
  logic [3:0]       rpt_freq;
  logic [CNT_W-1:0] rpt_frame;
  logic             ovf;
  logic [3:0]       cur_freq;
  logic             cur_vld;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  freq_report #(.STABLE_N(3), .CNT_W(CNT_W), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .freq      (freq),
    .rpt_ready (rpt_ready),
    .ovf_clr   (ovf_clr),
    .rpt_valid (rpt_valid),
    .rpt_freq  (rpt_freq),
    .rpt_frame (rpt_frame),
    .ovf       (ovf),
    .cur_freq  (cur_freq),
    .cur_vld   (cur_vld)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Captures every accepted report entry.
  always @(posedge clk) begin
    if (!rst && rpt_valid && rpt_ready) obs_q.push_back({rpt_freq, rpt_frame});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; done = 1'b0; rpt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse(input logic [3:0] f);
    @(negedge clk);
    done = 1'b1; freq = f;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic pulses(input logic [3:0] f, input int n);
    for (int i = 0; i < n; i++) pulse(f);
  endtask

  task automatic expect_entry(input logic [3:0] f, input logic [7:0] fr);
    exp_q.push_back({f, fr});
  endtask

  task automatic compare_reports(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_entry"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(input int cycles);
    @(negedge clk);
    rpt_ready = 1'b1;
    repeat (cycles) @(negedge clk);
    rpt_ready = 1'b0;
  endtask

  initial begin
    // Test 1: reset values and basic confirmation
    do_reset();
    check("rst_valid", rpt_valid, 0);
    check("rst_freq", rpt_freq, 0);
    check("rst_frame", rpt_frame, 0);
    check("rst_ovf", ovf, 0);
    check("rst_cur_freq", cur_freq, 0);
    check("rst_cur_vld", cur_vld, 0);
    pulses(4'd5, 2);
    check("t1_no_early", rpt_valid, 0);
    pulse(4'd5);
    check("t1_valid", rpt_valid, 1);
    check("t1_freq", rpt_freq, 5);
    check("t1_frame", rpt_frame, 2);
    check("t1_cur_freq", cur_freq, 5);
    check("t1_cur_vld", cur_vld, 1);
    @(negedge clk);
    check("t1_hold_freq", rpt_freq, 5);
    drain(1);
    check("t1_popped", rpt_valid, 0);
    check("t1_empty_hold", {rpt_freq, rpt_frame}, {4'd5, 8'd2});
    obs_q.delete();

    // Test 2: interrupted run, single report
    do_reset();
    rpt_ready = 1'b1;
    pulses(4'd5, 2); pulse(4'd7); pulses(4'd5, 3);
    @(negedge clk);
    rpt_ready = 1'b0;
    expect_entry(4'd5, 8'd5);
    compare_reports("t2");

    // Test 3: returning frequency equal to cur_freq is not re-reported
    do_reset();
    rpt_ready = 1'b1;
    pulses(4'd2, 3); pulses(4'd9, 2); pulses(4'd2, 3);
    @(negedge clk);
    rpt_ready = 1'b0;
    expect_entry(4'd2, 8'd2);
    compare_reports("t3");
    check("t3_cur_freq", cur_freq, 2);

    // Test 4: overflow drops the fifth report, tracking continues
    do_reset();
    pulses(4'd1, 3); pulses(4'd4, 3); pulses(4'd1, 3); pulses(4'd4, 3);
    check("t4_ovf_before", ovf, 0);
    pulses(4'd1, 3);
    check("t4_ovf", ovf, 1);
    check("t4_cur_freq", cur_freq, 1);
    drain(6);
    check("t4_empty", rpt_valid, 0);
    expect_entry(4'd1, 8'd2); expect_entry(4'd4, 8'd5);
    expect_entry(4'd1, 8'd8); expect_entry(4'd4, 8'd11);
    compare_reports("t4");
    check("t4_ovf_sticky", ovf, 1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("t4_ovf_clr", ovf, 0);

    // Test 5: full FIFO with simultaneous push and pop
    do_reset();
    pulses(4'd1, 3); pulses(4'd4, 3); pulses(4'd1, 3); pulses(4'd4, 3);
    pulses(4'd1, 2);
    @(negedge clk);
    done = 1'b1; freq = 4'd1; rpt_ready = 1'b1;
    @(negedge clk);
    done = 1'b0; rpt_ready = 1'b0;
    check("t5_ovf", ovf, 0);
    check("t5_valid", rpt_valid, 1);
    check("t5_head", {rpt_freq, rpt_frame}, {4'd4, 8'd5});
    drain(6);
    expect_entry(4'd1, 8'd2); expect_entry(4'd4, 8'd5); expect_entry(4'd1, 8'd8);
    expect_entry(4'd4, 8'd11); expect_entry(4'd1, 8'd14);
    compare_reports("t5");

    // Test 6: reset mid-stream discards queued entries
    do_reset();
    pulses(4'd3, 3); pulses(4'd6, 3);
    check("t6_queued", rpt_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", rpt_valid, 0);
    check("t6_rst_cur_vld", cur_vld, 0);
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    pulses(4'd0, 3);
    check("t6_valid", rpt_valid, 1);
    check("t6_entry", {rpt_freq, rpt_frame}, {4'd0, 8'd2});
    check("t6_cur_vld", cur_vld, 1);
    drain(2);
    check("t6_empty", rpt_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
